// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// The controller side is the master; the datapath side is the slave.
interface mips_multicycle_controller_if;
    logic [5:0] op;
    logic       zero;
    logic       memReady;
    logic       pcEn;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [1:0] aluOp;
    logic       illegalOp;
    logic [3:0] state_o;

    modport master (
        input  op, zero, memReady,
        output pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite,
               aluSrcA, aluSrcB, pcSrc, aluOp, illegalOp, state_o
    );

    modport slave (
        output op, zero, memReady,
        input  pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite,
               aluSrcA, aluSrcB, pcSrc, aluOp, illegalOp, state_o
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS-32 datapath: sequences fetch/decode/execute/
// memory/writeback and drives mux selects, write enables and the 2-bit aluOp.
module mips_multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic                           clk,
    input logic                           reset,
    mips_multicycle_controller_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state, state_nx;
    logic   mem_ok;
    logic   pc_write;
    logic   branch;
    logic   mem_write_raw;
    logic   ir_write_raw;
    logic   reg_write_raw;
    logic   illegal_raw;

    assign mem_ok = MEM_WAIT_EN ? bus.memReady : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = FETCH;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        bus.iorD      = 1'b0;
        bus.regDst    = 1'b0;
        bus.memToReg  = 1'b0;
        bus.aluSrcA   = 1'b0;
        bus.aluSrcB   = 2'b00;
        bus.pcSrc     = 2'b00;
        bus.aluOp     = 2'b00;
        unique case (state)
            FETCH: begin
                bus.aluSrcB  = 2'b01;
                ir_write_raw = mem_ok;
                pc_write     = mem_ok;
                state_nx     = mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                bus.aluSrcB = 2'b11;
                unique case (bus.op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_RTYPE:     state_nx = RTYPEEX;
                    OP_BEQ:       state_nx = BEQEX;
                    OP_ADDI:      state_nx = ADDIEX;
                    OP_J:         state_nx = JEX;
                    default: begin
                        state_nx    = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_nx    = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.iorD = 1'b1;
                state_nx = mem_ok ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.memToReg  = 1'b1;
                reg_write_raw = 1'b1;
            end
            MEMWR: begin
                bus.iorD      = 1'b1;
                mem_write_raw = mem_ok;
                state_nx      = mem_ok ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b10;
                state_nx    = RTYPEWB;
            end
            RTYPEWB: begin
                bus.regDst    = 1'b1;
                reg_write_raw = 1'b1;
            end
            BEQEX: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b01;
                bus.pcSrc   = 2'b01;
                branch      = 1'b1;
            end
            ADDIEX: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_nx    = ADDIWB;
            end
            ADDIWB: reg_write_raw = 1'b1;
            JEX: begin
                bus.pcSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: state_nx = FETCH;
        endcase
    end

    // Strobes are masked by reset so an abort in any state (e.g. a stalled MEMWR) cannot write.
    assign bus.pcEn      = ~reset & (pc_write | (branch & bus.zero));
    assign bus.memWrite  = ~reset & mem_write_raw;
    assign bus.irWrite   = ~reset & ir_write_raw;
    assign bus.regWrite  = ~reset & reg_write_raw;
    assign bus.illegalOp = ~reset & illegal_raw;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed-vector bench for the multicycle MIPS controller: walks each instruction class,
// stalls, illegal opcodes and reset aborts against hand-computed outputs.
module tb_mips_multicycle_controller;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mips_multicycle_controller_if bus ();

    mips_multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.op       = 6'b000000;
        bus.zero     = 1'b0;
        bus.memReady = 1'b1;
        step();
        step();

        // reset state
        check("rst_state",    bus.state_o,  4'd0);
        check("rst_irWrite",  bus.irWrite,  1'b0);
        check("rst_pcEn",     bus.pcEn,     1'b0);
        check("rst_regWrite", bus.regWrite, 1'b0);
        check("rst_aluSrcB",  bus.aluSrcB,  2'b01);

        reset = 1'b0;
        #1;
        check("fetch_irWrite", bus.irWrite, 1'b1);
        check("fetch_pcEn",    bus.pcEn,    1'b1);

        // lw: 0,1,2,3,4,0
        bus.op = 6'b100011;
        begin
            logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
            for (int i = 0; i < 6; i++) begin
                check("lw_state",    bus.state_o,  seq[i]);
                check("lw_aluOp",    bus.aluOp,    2'b00);
                check("lw_regWrite", bus.regWrite, (seq[i] == 4'd4));
                check("lw_memToReg", bus.memToReg, (seq[i] == 4'd4));
                if (i < 5) step();
            end
        end

        // R-type: 0,1,6,7,0
        bus.op = 6'b000000;
        step();
        check("r_dec",   bus.state_o, 4'd1);
        step();
        check("r_ex",    bus.state_o, 4'd6);
        check("r_aluOp", bus.aluOp,   2'b10);
        check("r_srcA",  bus.aluSrcA, 1'b1);
        step();
        check("r_wb",       bus.state_o,  4'd7);
        check("r_regDst",   bus.regDst,   1'b1);
        check("r_regWrite", bus.regWrite, 1'b1);
        step();
        check("r_back", bus.state_o, 4'd0);

        // beq taken
        bus.op   = 6'b000100;
        bus.zero = 1'b1;
        step();
        step();
        check("beq_state", bus.state_o, 4'd8);
        check("beq_pcEn1", bus.pcEn,    1'b1);
        check("beq_pcSrc", bus.pcSrc,   2'b01);
        check("beq_aluOp", bus.aluOp,   2'b01);
        step();
        check("beq_back", bus.state_o, 4'd0);

        // beq not taken
        bus.zero = 1'b0;
        step();
        step();
        check("beqn_state", bus.state_o, 4'd8);
        check("beqn_pcEn0", bus.pcEn,    1'b0);
        step();

        // addi: 0,1,9,10,0
        bus.op = 6'b001000;
        step();
        step();
        check("addi_ex",   bus.state_o, 4'd9);
        check("addi_srcB", bus.aluSrcB, 2'b10);
        step();
        check("addi_wb",       bus.state_o,  4'd10);
        check("addi_regWrite", bus.regWrite, 1'b1);
        step();

        // j: 0,1,11,0
        bus.op = 6'b000010;
        step();
        step();
        check("j_state", bus.state_o, 4'd11);
        check("j_pcSrc", bus.pcSrc,   2'b10);
        check("j_pcEn",  bus.pcEn,    1'b1);
        step();
        check("j_back", bus.state_o, 4'd0);

        // FETCH stall: no irWrite while memReady low
        bus.memReady = 1'b0;
        #1;
        check("fstall_irWrite", bus.irWrite, 1'b0);
        check("fstall_pcEn",    bus.pcEn,    1'b0);
        step();
        check("fstall_state", bus.state_o, 4'd0);
        bus.memReady = 1'b1;

        // sw with 3 stall cycles in MEMWR
        bus.op = 6'b101011;
        step();
        step();
        check("sw_adr", bus.state_o, 4'd2);
        step();
        bus.memReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", bus.state_o,  4'd5);
            check("sw_wait_mw",    bus.memWrite, 1'b0);
            step();
        end
        bus.memReady = 1'b1;
        #1;
        check("sw_last_state", bus.state_o,  4'd5);
        check("sw_last_mw",    bus.memWrite, 1'b1);
        check("sw_iorD",       bus.iorD,     1'b1);
        step();
        check("sw_back", bus.state_o,  4'd0);
        check("sw_mw0",  bus.memWrite, 1'b0);

        // illegal opcode
        bus.op = 6'b111111;
        step();
        check("ill_state", bus.state_o,   4'd1);
        check("ill_pulse", bus.illegalOp, 1'b1);
        check("ill_rw",    bus.regWrite,  1'b0);
        check("ill_mw",    bus.memWrite,  1'b0);
        step();
        check("ill_back", bus.state_o,   4'd0);
        check("ill_done", bus.illegalOp, 1'b0);

        // reset mid-MEMWR while stalled
        bus.op = 6'b101011;
        step();
        step();
        step();
        bus.memReady = 1'b0;
        #1;
        check("rmw_state", bus.state_o, 4'd5);
        reset = 1'b1;
        #1;
        check("rmw_abort_state", bus.state_o,  4'd0);
        check("rmw_abort_mw",    bus.memWrite, 1'b0);
        bus.memReady = 1'b1;
        #1;
        check("rmw_rst_mw", bus.memWrite, 1'b0);
        check("rmw_rst_ir", bus.irWrite,  1'b0);
        step();
        check("rmw_held", bus.state_o, 4'd0);
        reset = 1'b0;
        #1;
        check("rmw_rel_ir",   bus.irWrite, 1'b1);
        check("rmw_rel_pcEn", bus.pcEn,    1'b1);
        step();
        check("rmw_rel_dec", bus.state_o, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
